imem_arbiter: RTL and testbench

Single-port instruction-memory arbiter for the 8-bit CPU. It shares one synchronous 16x8 instruction RAM between the CPU fetch port and a host program-loader port. Arbitration is round-robin, and the loader may lock the RAM for a bounded burst. It drives the RAM, returns read data with a fixed 1-cycle latency, and raises a stall to the CPU whenever a fetch is refused.

---
 rtl/imem_pkg.sv | 26 ++
 rtl/rr_pick2.sv | 22 ++
 rtl/imem_arbiter.sv | 117 +++++++++++
 tb/tb_imem_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// imem_pkg: shared types and constants for the instruction-memory arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam int IMEM_ADDR_W = 4;
    localparam int IMEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } owner_e;

    // CPU opcodes, shared by the program loader and the CPU decoder
    localparam logic [7:0] OP_MOV = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h02;
    localparam logic [7:0] OP_CMP = 8'h03;
    localparam logic [7:0] OP_JE  = 8'h04;
    localparam logic [7:0] OP_JNE = 8'h05;
    localparam logic [7:0] OP_HLT = 8'h06;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rr_pick2: 2-way round-robin pick with a lock override favouring requester 1
// Rev 1.0
// -----------------------------------------------------------------------------
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic lock1,
    output logic gnt0,
    output logic gnt1
);

    // last = 0 means requester 0 won most recently, so requester 1 wins a tie
    always_comb begin
        gnt1 = req1 & (~req0 | lock1 | ~last);
        gnt0 = req0 & ~gnt1;
    end

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// imem_arbiter: shares one synchronous instruction RAM between CPU fetch and
// a host loader, with round-robin arbitration and bounded loader lock bursts
// Rev 1.0
// -----------------------------------------------------------------------------
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int DATA_W    = IMEM_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              cpu_stall,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    logic       last_q, last_d;
    owner_e     owner_q, owner_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic [1:0] rd_tag_q, rd_tag_d;
    logic       lock_q, lock_d;
    logic       lock_ovr;

    // Loader keeps the RAM only if it owned it and asked to keep it last cycle
    assign lock_ovr = (owner_q == LOAD) && lock_q && (burst_cnt_q < BURST_LIM);

    rr_pick2 u_pick (
        .req0  (f_req),
        .req1  (l_req),
        .last  (last_q),
        .lock1 (lock_ovr),
        .gnt0  (f_gnt),
        .gnt1  (l_gnt)
    );

    always_comb begin
        mem_en    = f_gnt | l_gnt;
        mem_we    = l_gnt & l_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (l_gnt) begin
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end
        cpu_stall = f_req & ~f_gnt;
        f_rvalid  = rd_tag_q[1];
        l_rvalid  = rd_tag_q[0];
        f_rdata   = rd_tag_q[1] ? mem_rdata : '0;
        l_rdata   = rd_tag_q[0] ? mem_rdata : '0;
    end

    always_comb begin
        last_d  = last_q;
        owner_d = IDLE;
        if (f_gnt) begin
            last_d  = 1'b0;
            owner_d = FETCH;
        end else if (l_gnt) begin
            last_d  = 1'b1;
            owner_d = LOAD;
        end

        // Only a locked loader burst against a waiting fetch is counted
        if (f_gnt || !f_req || !l_lock) begin
            burst_cnt_d = 4'd0;
        end else if (l_gnt && (burst_cnt_q < BURST_LIM)) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
            burst_cnt_d = burst_cnt_q;
        end

        rd_tag_d = {f_gnt, l_gnt & ~l_we};
        lock_d   = l_gnt & l_lock;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q      <= 1'b1;
            owner_q     <= IDLE;
            burst_cnt_q <= 4'd0;
            rd_tag_q    <= 2'b00;
            lock_q      <= 1'b0;
        end else begin
            last_q      <= last_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rd_tag_q    <= rd_tag_d;
            lock_q      <= lock_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_imem_arbiter: vector table plus read-return scoreboard for imem_arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          f_req = 1'b0, l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [AW-1:0] f_addr = '0, l_addr = '0;
    logic [DW-1:0] l_wdata = '0;
    logic          f_gnt, f_rvalid, cpu_stall, l_gnt, l_rvalid, mem_en, mem_we;
    logic [DW-1:0] f_rdata, l_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .cpu_stall(cpu_stall),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
        .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous 16x8 RAM; preload gives RAM[i] = 0x10 + i
    logic          preload = 1'b1;
    logic [DW-1:0] ram [16];
    logic [DW-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'(8'h10 + i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    typedef struct {
        logic          fr;
        logic [AW-1:0] fa;
        logic          lr, lw, lk;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        logic          efg, elg;
    } vec_t;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
    } rexp_t;

    rexp_t         fq[$];
    rexp_t         lq[$];
    logic [DW-1:0] model [16];
    logic [DW-1:0] prog [12];
    vec_t          vecs [19];
    int            checks = 0;
    int            errors = 0;
    int            stall_run = 0;

    function automatic vec_t mk(input logic fr, input logic [AW-1:0] fa,
                                input logic lr, input logic lw, input logic lk,
                                input logic [AW-1:0] la, input logic [DW-1:0] ld,
                                input logic efg, input logic elg);
        vec_t v;
        v.fr = fr; v.fa = fa; v.lr = lr; v.lw = lw; v.lk = lk;
        v.la = la; v.ld = ld; v.efg = efg; v.elg = elg;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h want %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; read returns from the previous cycle are popped here
    task automatic step(input vec_t v, input string tag);
        rexp_t fe, le;
        f_req = v.fr; f_addr = v.fa;
        l_req = v.lr; l_we = v.lw; l_lock = v.lk; l_addr = v.la; l_wdata = v.ld;
        @(negedge clk);
        fe = '{v: 1'b0, d: '0};
        le = '{v: 1'b0, d: '0};
        if (fq.size() > 0) fe = fq.pop_front();
        if (lq.size() > 0) le = lq.pop_front();
        chk1({tag, " f_rvalid"}, f_rvalid, fe.v);
        chk8({tag, " f_rdata"}, f_rdata, fe.v ? fe.d : 8'h00);
        chk1({tag, " l_rvalid"}, l_rvalid, le.v);
        chk8({tag, " l_rdata"}, l_rdata, le.v ? le.d : 8'h00);
        chk1({tag, " f_gnt"}, f_gnt, v.efg);
        chk1({tag, " l_gnt"}, l_gnt, v.elg);
        chk1({tag, " both_gnt"}, f_gnt & l_gnt, 1'b0);
        chk1({tag, " cpu_stall"}, cpu_stall, v.fr & ~v.efg);
        chk1({tag, " mem_en"}, mem_en, v.efg | v.elg);
        chk1({tag, " mem_we"}, mem_we, v.elg & v.lw);
        chk8({tag, " mem_addr"}, 8'(mem_addr), v.efg ? 8'(v.fa) : (v.elg ? 8'(v.la) : 8'h00));
        chk8({tag, " mem_wdata"}, mem_wdata, v.elg ? v.ld : 8'h00);
        stall_run = cpu_stall ? stall_run + 1 : 0;
        chk1({tag, " stall_run_le_max"}, stall_run > MB, 1'b0);
        fq.push_back('{v: v.efg, d: model[v.fa]});
        lq.push_back('{v: v.elg & ~v.lw, d: model[v.la]});
        if (v.elg && v.lw) model[v.la] = v.ld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 8'(8'h10 + i);
        prog = '{OP_MOV, 8'h0A, OP_ADD, 8'h05, OP_CMP, 8'h0F,
                 OP_JE,  8'h0A, OP_JNE, 8'h00, OP_HLT, 8'h00};

        //            fr fa lr lw lk la ld     efg elg
        vecs[0]  = mk(1, 3, 0, 0, 0, 0, 8'h00, 1, 0);  // fetch RAM[3]
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        vecs[2]  = mk(0, 0, 1, 1, 0, 5, 8'h2A, 0, 1);  // write 5
        vecs[3]  = mk(0, 0, 1, 0, 0, 5, 8'h00, 0, 1);  // read 5 straight after
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        vecs[5]  = mk(1, 3, 1, 0, 0, 5, 8'h00, 1, 0);  // unlocked alternation
        vecs[6]  = mk(1, 3, 1, 0, 0, 5, 8'h00, 0, 1);
        vecs[7]  = mk(1, 3, 1, 0, 0, 5, 8'h00, 1, 0);
        vecs[8]  = mk(1, 3, 1, 0, 0, 5, 8'h00, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        vecs[10] = mk(1, 8, 1, 0, 1, 7, 8'h00, 1, 0);  // locked burst
        vecs[11] = mk(1, 8, 1, 0, 1, 7, 8'h00, 0, 1);
        vecs[12] = mk(1, 8, 1, 0, 1, 7, 8'h00, 0, 1);
        vecs[13] = mk(1, 8, 1, 0, 1, 7, 8'h00, 0, 1);
        vecs[14] = mk(1, 8, 1, 0, 1, 7, 8'h00, 0, 1);
        vecs[15] = mk(1, 8, 1, 0, 1, 7, 8'h00, 1, 0);  // burst limit reached
        vecs[16] = mk(1, 9, 1, 0, 1, 7, 8'h00, 0, 1);
        vecs[17] = mk(1, 9, 1, 0, 1, 7, 8'h00, 0, 1);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst f_rvalid", f_rvalid, 1'b0);
        chk1("rst l_rvalid", l_rvalid, 1'b0);
        chk8("rst f_rdata", f_rdata, 8'h00);
        chk8("rst l_rdata", l_rdata, 8'h00);
        chk1("rst mem_en", mem_en, 1'b0);
        chk1("rst mem_we", mem_we, 1'b0);
        chk8("rst mem_addr", 8'(mem_addr), 8'h00);
        chk8("rst mem_wdata", mem_wdata, 8'h00);
        f_req = 1'b1;
        #1;
        chk1("rst f_gnt follows req", f_gnt, 1'b1);
        chk1("rst cpu_stall", cpu_stall, 1'b0);
        f_req = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        preload = 1'b0;

        for (int i = 0; i < 19; i++) step(vecs[i], $sformatf("vec%0d", i));

        // Reset while a fetch read is in flight
        step(mk(1, 2, 0, 0, 0, 0, 8'h00, 1, 0), "pre_rst");
        reset_n = 1'b0;
        f_req = 1'b0;
        fq.delete();
        lq.delete();
        @(negedge clk);
        chk1("mid_rst f_rvalid", f_rvalid, 1'b0);
        chk8("mid_rst f_rdata", f_rdata, 8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(mk(1, 4, 1, 0, 0, 6, 8'h00, 1, 0), "post_rst_tie");
        step(mk(0, 0, 1, 0, 0, 6, 8'h00, 0, 1), "post_rst_ld");
        step(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0), "post_rst_idle");

        // Program load, then fetch it back
        for (int i = 0; i < 12; i++)
            step(mk(0, 0, 1, 1, 0, 4'(i), prog[i], 0, 1), $sformatf("load%0d", i));
        for (int i = 0; i < 12; i++)
            step(mk(1, 4'(i), 0, 0, 0, 0, 8'h00, 1, 0), $sformatf("fetch%0d", i));
        step(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0), "drain");
        for (int i = 0; i < 12; i++)
            chk8($sformatf("prog_model%0d", i), model[i], prog[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
